// File: rtl/nand_nor_logic.sv
// Universal-gate demonstrator: NAND/NOR outputs, dual NAND-only/NOR-only function
// networks with registered cross-check, and truth-table coverage tracking.
`timescale 1ns/1ps
module nand_nor_logic #(
  parameter bit STICKY_ERR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  output logic       out1,
  output logic       out2,
  output logic [7:0] fn_q,
  output logic       err_q,
  output logic [3:0] seen_q,
  output logic       cov_done
);

  localparam int unsigned FN_W   = 8;
  localparam int unsigned SEEN_W = 4;

  // Direct gate-level NAND / NOR outputs
  nand u_out1 (out1, a, b);
  nor  u_out2 (out2, a, b);

  // NAND-only network
  wire nd_na, nd_nb, nd_nand, nd_and, nd_or, nd_nor, nd_t1, nd_t2, nd_xor, nd_xnor;
  nand u_nd_na   (nd_na,   a,       a);
  nand u_nd_nb   (nd_nb,   b,       b);
  nand u_nd_nand (nd_nand, a,       b);
  nand u_nd_and  (nd_and,  nd_nand, nd_nand);
  nand u_nd_or   (nd_or,   nd_na,   nd_nb);
  nand u_nd_nor  (nd_nor,  nd_or,   nd_or);
  nand u_nd_t1   (nd_t1,   a,       nd_nand);
  nand u_nd_t2   (nd_t2,   b,       nd_nand);
  nand u_nd_xor  (nd_xor,  nd_t1,   nd_t2);
  nand u_nd_xnor (nd_xnor, nd_xor,  nd_xor);

  // NOR-only network (dual constructions; XNOR is the 4-NOR form)
  wire nr_na, nr_nb, nr_nor, nr_or, nr_and, nr_nand, nr_u1, nr_u2, nr_xnor, nr_xor;
  nor u_nr_na   (nr_na,   a,       a);
  nor u_nr_nb   (nr_nb,   b,       b);
  nor u_nr_nor  (nr_nor,  a,       b);
  nor u_nr_or   (nr_or,   nr_nor,  nr_nor);
  nor u_nr_and  (nr_and,  nr_na,   nr_nb);
  nor u_nr_nand (nr_nand, nr_and,  nr_and);
  nor u_nr_u1   (nr_u1,   a,       nr_nor);
  nor u_nr_u2   (nr_u2,   b,       nr_nor);
  nor u_nr_xnor (nr_xnor, nr_u1,   nr_u2);
  nor u_nr_xor  (nr_xor,  nr_xnor, nr_xnor);

  logic [FN_W-1:0] nand_vec_c;
  logic [FN_W-1:0] nor_vec_c;
  assign nand_vec_c = {nd_xnor, nd_xor, nd_nor, nd_nand, nd_or, nd_and, nd_nb, nd_na};
  assign nor_vec_c  = {nr_xnor, nr_xor, nr_nor, nr_nand, nr_or, nr_and, nr_nb, nr_na};

  logic [FN_W-1:0]   fn_d;
  logic              err_d;
  logic [SEEN_W-1:0] seen_d;
  logic              cmp_c;

  // Next-state for the registered path
  always_comb begin
    fn_d   = nand_vec_c;
    seen_d = seen_q;
    cmp_c  = (nand_vec_c != nor_vec_c);
    err_d  = cmp_c;
    seen_d[{a, b}] = 1'b1;
    if (STICKY_ERR) begin
      err_d = err_q | cmp_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fn_q   <= FN_W'(0);
      err_q  <= 1'b0;
      seen_q <= SEEN_W'(0);
    end else begin
      fn_q   <= fn_d;
      err_q  <= err_d;
      seen_q <= seen_d;
    end
  end

  assign cov_done = &seen_q;

endmodule

// File: tb/tb_nand_nor_logic.sv
// Self-checking bench for nand_nor_logic: truth-table reference model with
// directed and random stimulus, reset and fault-injection scenarios.
`timescale 1ns/1ps
module tb_nand_nor_logic;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       out1, out2, err_q, cov_done;
  logic [7:0] fn_q;
  logic [3:0] seen_q;
  logic       out1_n, out2_n, err_q_n, cov_done_n;
  logic [7:0] fn_q_n;
  logic [3:0] seen_q_n;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference: function vector per {a,b}, derived from the bit map by hand
  logic [7:0] fn_tab [4];
  logic [7:0] exp_fn;
  logic [3:0] exp_seen;
  int         cyc;
  int         first00_cyc;
  int         cov_cyc;

  nand_nor_logic #(.STICKY_ERR(1'b1)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .out1(out1), .out2(out2),
    .fn_q(fn_q), .err_q(err_q), .seen_q(seen_q), .cov_done(cov_done)
  );

  nand_nor_logic #(.STICKY_ERR(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .a(a), .b(b), .out1(out1_n), .out2(out2_n),
    .fn_q(fn_q_n), .err_q(err_q_n), .seen_q(seen_q_n), .cov_done(cov_done_n)
  );

  always #2.5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Combinational outputs against the truth table of NAND/NOR
  task automatic check_comb(input string tag);
    check({tag, "_out1"}, 8'(out1), 8'((a && b) ? 0 : 1));
    check({tag, "_out2"}, 8'(out2), 8'((a || b) ? 0 : 1));
  endtask

  task automatic drive(input logic na, input logic nb, input logic nr);
    @(negedge clk);
    a = na; b = nb; rst = nr;
    #1;
    check_comb("comb");
  endtask

  // Advance one edge, update the model, compare registered outputs
  task automatic tick(input logic exp_err, input logic exp_err_n);
    @(posedge clk);
    if (rst) begin
      exp_fn   = 8'h00;
      exp_seen = 4'b0000;
    end else begin
      exp_fn = fn_tab[{a, b}];
      exp_seen[{a, b}] = 1'b1;
    end
    #1;
    cyc++;
    check("fn_q",       fn_q,             exp_fn);
    check("seen_q",     8'(seen_q),       8'(exp_seen));
    check("cov_done",   8'(cov_done),     8'(&exp_seen));
    check("err_q",      8'(err_q),        8'(exp_err));
    check("fn_q_ns",    fn_q_n,           exp_fn);
    check("err_q_ns",   8'(err_q_n),      8'(exp_err_n));
  endtask

  initial begin
    fn_tab[0] = 8'hB3;
    fn_tab[1] = 8'h59;
    fn_tab[2] = 8'h5A;
    fn_tab[3] = 8'h8C;
    exp_fn = 8'h00;
    exp_seen = 4'b0000;
    cyc = 0;
    first00_cyc = -1;
    cov_cyc = -1;

    // Exhaustive combinational: 00,10,01,11 -> (1,1),(1,0),(1,0),(0,0)
    a = 0; b = 0; #1; check("ex00_out1", 8'(out1), 8'd1); check("ex00_out2", 8'(out2), 8'd1);
    a = 1; b = 0; #1; check("ex10_out1", 8'(out1), 8'd1); check("ex10_out2", 8'(out2), 8'd0);
    a = 0; b = 1; #1; check("ex01_out1", 8'(out1), 8'd1); check("ex01_out2", 8'(out2), 8'd0);
    a = 1; b = 1; #1; check("ex11_out1", 8'(out1), 8'd0); check("ex11_out2", 8'(out2), 8'd0);

    // Reset two cycles
    drive(1'b1, 1'b1, 1'b1); tick(1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1); tick(1'b0, 1'b0);

    // Registered vector directed cases
    drive(1'b1, 1'b0, 1'b0); tick(1'b0, 1'b0);
    check("fn_10", fn_q, 8'b0101_1010);
    drive(1'b1, 1'b1, 1'b0); tick(1'b0, 1'b0);
    check("fn_11", fn_q, 8'b1000_1100);

    // Toggle pattern after a fresh reset: a every 10 ns, b every 20 ns
    drive(1'b0, 1'b0, 1'b1); tick(1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1); tick(1'b0, 1'b0);
    for (int i = 0; i < 80; i++) begin
      drive(1'((i / 2) % 2), 1'((i / 4) % 2), 1'b0);
      if (first00_cyc < 0 && !a && !b) first00_cyc = cyc + 1;
      tick(1'b0, 1'b0);
      if (cov_cyc < 0 && cov_done) cov_cyc = cyc;
    end
    check("cov_latency_ok", 8'((cov_cyc >= 0 && (cov_cyc - first00_cyc) <= 8) ? 1 : 0), 8'd1);

    // Reset mid-run with a=b=1
    check("pre_rst_cov", 8'(cov_done), 8'd1);
    drive(1'b1, 1'b1, 1'b1); tick(1'b0, 1'b0);
    check("rst_fn", fn_q, 8'h00);
    check("rst_seen", 8'(seen_q), 8'h00);
    check("rst_out1", 8'(out1), 8'd0);
    check("rst_out2", 8'(out2), 8'd0);

    // Random cross-check run
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      tick(1'b0, 1'b0);
    end

    // Fault injection on a NOR-network net for one cycle
    drive(1'b1, 1'b0, 1'b0);
    force dut.nr_or = 1'b0;
    force dut_ns.nr_or = 1'b0;
    tick(1'b1, 1'b1);
    release dut.nr_or;
    release dut_ns.nr_or;
    drive(1'b1, 1'b0, 1'b0); tick(1'b1, 1'b0);
    drive(0, 1'b1, 1'b0);    tick(1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1); tick(1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nand_nor_logic.md
Name: nand_nor_logic

Overview:
- Universal-gate demonstrator block. Produces 2-input NAND and NOR of inputs a/b combinationally (out1, out2), built at gate level.
- Also derives the full set of basic 2-input functions twice, once from a NAND-only network and once from a NOR-only network.
- Registers the NAND-network results and cross-checks the two networks.
- Tracks which input combinations have been applied since reset (truth-table coverage).
- Used as a leaf teaching/self-check cell. No upstream handshake.

Parameters:
STICKY_ERR, 1, 1 = err_q stays set until reset once set; 0 = err_q reflects the current cycle's compare only

Ports:
clk        input   1  rising-edge clock for all registered outputs
rst        input   1  synchronous, active-high reset
a          input   1  operand A
b          input   1  operand B
out1       output  1  combinational ~(a & b), NAND
out2       output  1  combinational ~(a | b), NOR
fn_q       output  8  registered function vector from NAND-only network (bit map below)
err_q      output  1  registered mismatch flag, NAND-network vs NOR-network
seen_q     output  4  registered coverage mask; bit index = {a,b}
cov_done   output  1  combinational &seen_q

Behaviour:
- out1/out2:
  - Pure combinational, zero latency.
  - Independent of clk and rst.
  - Must be built from gate primitives (nand, nor).
- fn vector bit map:
  - [0] ~a
  - [1] ~b
  - [2] a&b
  - [3] a|b
  - [4] ~(a&b)
  - [5] ~(a|b)
  - [6] a^b
  - [7] ~(a^b)
- NAND network: every bit is produced using only 2-input nand primitives.
  - NOT = nand(x,x).
  - AND = NOT of NAND.
  - OR = nand(~a,~b).
  - XOR = standard 4-NAND form.
  - XNOR = NOT of XOR.
  - NOR = NOT of OR.
- NOR network: the same 8 functions, produced using only 2-input nor primitives (dual constructions).
- Registered path, on each rising clk:
  - If rst=1: fn_q <= 8'h00, err_q <= 0, seen_q <= 4'b0000.
  - Else:
    - fn_q <= NAND-network vector.
    - seen_q[{a,b}] <= 1; other bits hold.
    - cmp = (nand_vec != nor_vec).
    - err_q <= STICKY_ERR ? (err_q | cmp) : cmp.
- Latency: fn_q, err_q and seen_q reflect inputs sampled at the previous rising edge (1 cycle).
- cov_done:
  - Asserted combinationally once all four combinations (00, 01, 10, 11) have been sampled.
  - Deasserts one edge after rst is sampled high.
- err_q must never assert in a correct implementation. It exists so the verifier can force or inject a net fault.
- Reset mid-operation:
  - Registered outputs clear at the next edge regardless of a/b.
  - The a/b sampled in the reset cycle are not recorded in seen_q.
- Inputs are assumed synchronous to clk for registered outputs. No synchronizers.

Test Plan:
- Exhaustive combinational: apply (a,b) = 00, 10, 01, 11 -> (out1,out2) = (1,1), (1,0), (1,0), (0,0), with no clock required.
- Toggle pattern:
  - Stimulus: clk period 5 ns, rst high 2 cycles then low; a toggles every 10 ns, b every 20 ns, run 400 ns.
  - Required response: out1/out2 match NAND/NOR at every change; cov_done=1 within 40 ns after the first post-reset sample of 00.
- Registered vector:
  - a=1, b=0 held across an edge -> fn_q = 8'b0101_1010 ([0]=0, [1]=1, [2]=0, [3]=1, [4]=1, [5]=0, [6]=1, [7]=0).
  - a=1, b=1 -> fn_q = 8'b1000_1100.
- Reset mid-run:
  - Stimulus: after cov_done=1 and fn_q nonzero, assert rst for 1 edge with a=b=1.
  - Required response: fn_q=0, seen_q=0, cov_done=0, err_q=0; out1=0 and out2=0 unchanged throughout.
- Error flag:
  - Force one NOR-network internal net for one cycle -> err_q=1 next edge.
  - With STICKY_ERR=1, err_q stays 1 after the force is released until rst.
  - With STICKY_ERR=0, err_q clears one edge after release.
- Cross-check: every cycle over a 400 ns random run, fn_q[4] equals the out1 and fn_q[5] equals the out2 of the previous cycle; err_q stays 0.
